ex_muldiv: RTL and testbench

Iterative multiply/divide unit in the EX stage, directly downstream of the ID/EX pipeline register. Consumes the register operands and EX control latched by ID/EX, computes MULT/MULTU/DIV/DIVU over WIDTH+1 cycles and holds the results in architectural HI/LO registers. Asserts a stall toward the IF/ID and ID/EX registers while an operation is in flight.

---
 rtl/ex_muldiv_pkg.sv | 27 ++
 rtl/ex_muldiv_if.sv | 16 +
 rtl/ex_muldiv_step.sv | 47 ++++
 rtl/ex_muldiv.sv | 152 +++++++++++++++
 tb/tb_ex_muldiv.sv | 196 +++++++++++++++++++
 5 files changed

// File: rtl/ex_muldiv_pkg.sv
// Shared definitions for the EX-stage iterative multiply/divide unit.
// Optional divide datapath: define MULDIV_DIV_EN to make DIV/DIVU legal.
package muldiv_pkg;

  localparam int unsigned DEF_WIDTH = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    SIGN = 2'd2
  } state_t;

  // Operations this build is able to execute.
  function automatic logic op_legal(input logic [1:0] op);
`ifdef MULDIV_DIV_EN
    return (op == OP_MULT) || (op == OP_MULTU) || (op == OP_DIV) || (op == OP_DIVU);
`else
    return (op == OP_MULT) || (op == OP_MULTU);
`endif
  endfunction

endpackage

// File: rtl/ex_muldiv_if.sv
// Handshake/operand bundle between ID/EX control and the multiply/divide unit.
interface ex_muldiv_if #(parameter int unsigned WIDTH = muldiv_pkg::DEF_WIDTH);
  logic             start;
  logic [1:0]       op;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             flush;
  logic             busy;
  logic             stall;
  logic             done;
  logic [WIDTH-1:0] hi;
  logic [WIDTH-1:0] lo;

  modport master (output start, op, a, b, flush, input busy, stall, done, hi, lo);
  modport slave  (input start, op, a, b, flush, output busy, stall, done, hi, lo);
endinterface

// File: rtl/ex_muldiv_step.sv
// One radix-2 iteration: shift-add for multiply, restoring trial subtract
// for divide (divide path only with MULDIV_DIV_EN).
module muldiv_step #(
  parameter int unsigned WIDTH = 32
) (
`ifdef MULDIV_DIV_EN
  input  logic             is_div,
`endif
  input  logic [WIDTH-1:0] hi_in,
  input  logic [WIDTH-1:0] lo_in,
  input  logic [WIDTH-1:0] opnd,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out
);

  logic [WIDTH:0] sum;

`ifdef MULDIV_DIV_EN
  logic [WIDTH:0] rem;
  logic [WIDTH:0] diff;

  // Trial subtraction of the divisor from the shifted partial remainder.
  always_comb begin
    rem  = {hi_in, lo_in[WIDTH-1]};
    diff = rem - {1'b0, opnd};
  end
`endif

  // Select multiply add-or-pass result, or divide restore/keep result.
  always_comb begin
    sum    = {1'b0, hi_in} + (lo_in[0] ? {1'b0, opnd} : '0);
    hi_out = sum[WIDTH:1];
    lo_out = {sum[0], lo_in[WIDTH-1:1]};
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      if (!diff[WIDTH]) begin
        hi_out = diff[WIDTH-1:0];
        lo_out = {lo_in[WIDTH-2:0], 1'b1};
      end else begin
        hi_out = rem[WIDTH-1:0];
        lo_out = {lo_in[WIDTH-2:0], 1'b0};
      end
    end
`endif
  end

endmodule

// File: rtl/ex_muldiv.sv
// EX-stage iterative MULT/MULTU/DIV/DIVU unit with architectural HI/LO.
// Latency WIDTH+1 cycles; stalls upstream while in flight.
// Optional divide datapath: define MULDIV_DIV_EN (default: multiply only).
module ex_muldiv
  import muldiv_pkg::*;
#(
  parameter int unsigned WIDTH = DEF_WIDTH
) (
  input logic        clk,
  input logic        rst_n,
  ex_muldiv_if.slave bus
);

  localparam int unsigned CW = $clog2(WIDTH);

  state_t           state;
  logic [CW-1:0]    cnt;
  logic [WIDTH-1:0] acc_hi;
  logic [WIDTH-1:0] acc_lo;
  logic [WIDTH-1:0] opnd;
  logic [WIDTH-1:0] hi_r;
  logic [WIDTH-1:0] lo_r;
  logic             neg_lo;

`ifdef MULDIV_DIV_EN
  logic             is_div;
  logic             neg_hi;
  logic             divz;
`endif

  logic             signed_op;
  logic             sgn_a;
  logic             sgn_b;
  logic [WIDTH-1:0] mag_a;
  logic [WIDTH-1:0] mag_b;
  logic             accept;
  logic             busy;
  logic [WIDTH-1:0] step_hi;
  logic [WIDTH-1:0] step_lo;
  logic [WIDTH-1:0] res_hi;
  logic [WIDTH-1:0] res_lo;

  // Operand magnitudes/signs and request qualification.
  always_comb begin
    signed_op = ~bus.op[0];
    sgn_a     = signed_op & bus.a[WIDTH-1];
    sgn_b     = signed_op & bus.b[WIDTH-1];
    mag_a     = sgn_a ? -bus.a : bus.a;
    mag_b     = sgn_b ? -bus.b : bus.b;
    accept    = bus.start & op_legal(bus.op) & ~bus.flush;
  end

  muldiv_step #(.WIDTH(WIDTH)) u_step (
`ifdef MULDIV_DIV_EN
    .is_div (is_div),
`endif
    .hi_in  (acc_hi),
    .lo_in  (acc_lo),
    .opnd   (opnd),
    .hi_out (step_hi),
    .lo_out (step_lo)
  );

  // Sign fix-up of the raw magnitude result. Divide by zero leaves the
  // remainder equal to |a| (sign-restored to a) and forces an all-ones quotient.
  always_comb begin
    res_hi = acc_hi;
    res_lo = acc_lo;
`ifdef MULDIV_DIV_EN
    if (is_div) begin
      if (neg_hi) res_hi = -acc_hi;
      if (divz) res_lo = '1;
      else if (neg_lo) res_lo = -acc_lo;
    end else if (neg_lo) begin
      {res_hi, res_lo} = -{acc_hi, acc_lo};
    end
`else
    if (neg_lo) {res_hi, res_lo} = -{acc_hi, acc_lo};
`endif
  end

  // Control FSM plus iteration datapath and HI/LO registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state  <= IDLE;
      cnt    <= '0;
      acc_hi <= '0;
      acc_lo <= '0;
      opnd   <= '0;
      hi_r   <= '0;
      lo_r   <= '0;
      neg_lo <= 1'b0;
`ifdef MULDIV_DIV_EN
      is_div <= 1'b0;
      neg_hi <= 1'b0;
      divz   <= 1'b0;
`endif
    end else if (bus.flush) begin
      state <= IDLE;
      cnt   <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (accept) begin
            acc_hi <= '0;
            neg_lo <= sgn_a ^ sgn_b;
            cnt    <= '0;
            state  <= CALC;
`ifdef MULDIV_DIV_EN
            is_div <= bus.op[1];
            neg_hi <= sgn_a;
            divz   <= (bus.b == '0);
            if (bus.op[1]) begin
              acc_lo <= mag_a;
              opnd   <= mag_b;
            end else begin
              acc_lo <= mag_b;
              opnd   <= mag_a;
            end
`else
            acc_lo <= mag_b;
            opnd   <= mag_a;
`endif
          end
        end
        CALC: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          cnt    <= cnt + 1'b1;
          if (cnt == CW'(WIDTH - 1)) state <= SIGN;
        end
        SIGN: begin
          hi_r  <= res_hi;
          lo_r  <= res_lo;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

  // Status outputs decoded from state and current request.
  always_comb begin
    busy      = (state != IDLE);
    bus.busy  = busy;
    bus.stall = busy | accept;
    bus.done  = (state == SIGN) & ~bus.flush;
    bus.hi    = hi_r;
    bus.lo    = lo_r;
  end

endmodule

// File: tb/tb_ex_muldiv.sv
// Scoreboard bench for ex_muldiv; adapts divide tests to MULDIV_DIV_EN.
module tb_ex_muldiv;
  import muldiv_pkg::*;

  localparam int unsigned W = 32;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  ex_muldiv_if #(.WIDTH(W)) bus();

  ex_muldiv #(.WIDTH(W)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  int unsigned n_chk = 0;
  int unsigned n_err = 0;
  logic [63:0] exp_q[$];
  logic [63:0] pexp;
  logic [63:0] last_hl = '0;
  bit          pend = 1'b0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, act, exp);
    end
  endtask

  function automatic bit tb_legal(input logic [1:0] o);
`ifdef MULDIV_DIV_EN
    return 1'b1;
`else
    return ~o[1];
`endif
  endfunction

  function automatic logic [63:0] model(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y);
    logic signed [63:0] sx, sy, q, r;
    sx = {{32{x[31]}}, x};
    sy = {{32{y[31]}}, y};
    case (o)
      OP_MULT:  return sx * sy;
      OP_MULTU: return {32'b0, x} * {32'b0, y};
      OP_DIV: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        q = sx / sy;
        r = sx % sy;
        return {r[31:0], q[31:0]};
      end
      default: begin
        if (y == 32'd0) return {x, 32'hFFFF_FFFF};
        return {x % y, x / y};
      end
    endcase
  endfunction

  // Scoreboard monitor: on done, pop expectation; compare HI/LO after the write edge.
  always @(negedge clk) begin
    if (pend) begin
      check("hilo", {bus.hi, bus.lo}, pexp);
      pend = 1'b0;
    end
    if (bus.done) begin
      if (exp_q.size() == 0) begin
        check("spurious_done", {63'b0, bus.done}, 64'd0);
      end else begin
        pexp = exp_q.pop_front();
        pend = 1'b1;
      end
    end
  end

  // Issue one operation, optionally poking a second start mid-flight, and
  // check latency plus busy/stall while in flight.
  task automatic run_op(input logic [1:0] o, input logic [31:0] x, input logic [31:0] y, input int poke);
    int lat;
    bit ok;
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = o; bus.a = x; bus.b = y;
    #1 check("stall_req", {63'b0, bus.stall}, 64'd1);
    exp_q.push_back(model(o, x, y));
    last_hl = model(o, x, y);
    @(posedge clk); #1;
    bus.start = 1'b0;
    lat = 1;
    ok = 1'b1;
    while (lat < 60) begin
      @(negedge clk);
      if (bus.done) break;
      if (!(bus.busy && bus.stall)) ok = 1'b0;
      if (poke != 0 && lat == poke) begin
        bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd7; bus.b = 32'd7;
      end else begin
        bus.start = 1'b0;
      end
      @(posedge clk);
      lat++;
    end
    bus.start = 1'b0;
    check("busy_stall", {63'b0, ok}, 64'd1);
    check("latency", 64'(lat), 64'd33);
  endtask

  initial begin
    logic [1:0] ro;
    bus.start = 1'b0; bus.op = '0; bus.a = '0; bus.b = '0; bus.flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_busy", {63'b0, bus.busy}, 64'd0);
    check("rst_done", {63'b0, bus.done}, 64'd0);
    check("rst_stall", {63'b0, bus.stall}, 64'd0);
    check("rst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk) rst_n = 1'b1;

    run_op(OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 0);
    run_op(OP_MULT, 32'hFFFF_FFFD, 32'd7, 0);
    run_op(OP_MULT, 32'h8000_0000, 32'h8000_0000, 0);
`ifdef MULDIV_DIV_EN
    run_op(OP_DIV, 32'hFFFF_FFF9, 32'd2, 0);
    run_op(OP_DIV, 32'h8000_0000, 32'hFFFF_FFFF, 0);
    run_op(OP_DIVU, 32'h0000_1234, 32'd0, 0);
    run_op(OP_DIV, 32'hFFFF_FFFB, 32'd0, 0);
    run_op(OP_DIVU, 32'd100, 32'd7, 0);
    run_op(OP_DIV, 32'd100, 32'hFFFF_FFF9, 0);
`else
    // Divide requests must be rejected outright in a multiply-only build.
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = OP_DIV; bus.a = 32'd50; bus.b = 32'd5;
    #1 check("illegal_stall", {63'b0, bus.stall}, 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0;
    check("illegal_busy", {63'b0, bus.busy}, 64'd0);
    repeat (40) @(posedge clk);
    #1 check("illegal_hilo", {bus.hi, bus.lo}, last_hl);
`endif

    // Second start while busy must be dropped.
    run_op(OP_MULTU, 32'd5, 32'd5, 5);

    for (int i = 0; i < 8; i++) begin
      ro = 2'($urandom_range(0, 3));
      if (!tb_legal(ro)) ro[1] = 1'b0;
      run_op(ro, $urandom, (i == 3) ? 32'd1 : $urandom, 0);
    end

    // Flush mid-operation leaves HI/LO untouched and produces no done.
    run_op(OP_MULTU, 32'd2, 32'd3, 0);
    @(posedge clk); #1;
    bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd5; bus.b = 32'd5;
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (9) @(posedge clk);
    #1 bus.flush = 1'b1;
    @(posedge clk); #1;
    bus.flush = 1'b0;
    check("flush_busy", {63'b0, bus.busy}, 64'd0);
    repeat (40) @(posedge clk);
    #1 check("flush_hilo", {bus.hi, bus.lo}, 64'd6);
    bus.start = 1'b1; bus.op = OP_MULTU; bus.flush = 1'b1;
    #1 check("flush_start_stall", {63'b0, bus.stall}, 64'd0);
    @(posedge clk); #1;
    bus.start = 1'b0; bus.flush = 1'b0;
    check("flush_start_busy", {63'b0, bus.busy}, 64'd0);

    // Asynchronous reset in the middle of an operation.
    @(posedge clk); #1;
`ifdef MULDIV_DIV_EN
    bus.start = 1'b1; bus.op = OP_DIVU; bus.a = 32'd1000; bus.b = 32'd7;
`else
    bus.start = 1'b1; bus.op = OP_MULTU; bus.a = 32'd1000; bus.b = 32'd7;
`endif
    @(posedge clk); #1;
    bus.start = 1'b0;
    repeat (14) @(posedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {63'b0, bus.busy}, 64'd0);
    check("arst_done", {63'b0, bus.done}, 64'd0);
    check("arst_hilo", {bus.hi, bus.lo}, 64'd0);
    @(negedge clk) rst_n = 1'b1;
    repeat (40) @(posedge clk);
    #1 check("arst_idle", {63'b0, bus.busy}, 64'd0);

    repeat (3) @(posedge clk);
    check("drain", 64'(exp_q.size()), 64'd0);
    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end

endmodule
